instr_fetch_unit: RTL and testbench

//  Instruction fetch stage: holds the PC, reads a local synchronous instruction memory and

---
 rtl/fetch_pkg.sv | 31 +++
 rtl/fetch_fifo.sv | 97 +++++++++
 rtl/instr_fetch_unit.sv | 179 +++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// ----------------------------------------------------------------------------
// fetch_pkg
// Shared types and constants for the instruction fetch stage.
//   fetch_state_e : fetch controller states (IDLE, FETCH, HALT)
//   fetch_entry_t : one buffered fetch result {instr, pc}
//   EBREAK_INSTR  : encoding that stops further fetching
//   NOP_INSTR     : canonical ADDI x0,x0,0
//   align_pc()    : clears the byte-offset bits of a PC
// ----------------------------------------------------------------------------
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HALT  = 2'd2
  } fetch_state_e;

  localparam logic [31:0] EBREAK_INSTR = 32'h0010_0073;
  localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

  // Force a PC onto a word boundary.
  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// ----------------------------------------------------------------------------
// fetch_fifo
// Synchronous FIFO of fetch_entry_t. Flush has priority over push/pop.
// A push while full is accepted when a pop happens in the same cycle.
// Ports:
//   i_clk, i_rst     : clock, synchronous active-high reset
//   i_flush          : drop all entries
//   i_push/i_push_data : enqueue request and data
//   i_pop            : dequeue request (ignored when empty)
//   o_head           : oldest entry (undefined when empty)
//   o_count          : number of stored entries
//   o_full/o_empty   : occupancy flags
// ----------------------------------------------------------------------------
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_flush,
  input  logic             i_push,
  input  fetch_entry_t     i_push_data,
  input  logic             i_pop,
  output fetch_entry_t     o_head,
  output logic [CNT_W-1:0] o_count,
  output logic             o_full,
  output logic             o_empty
);

  fetch_entry_t     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  // Pointer increment with wrap at DEPTH (DEPTH need not be a power of 2).
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    logic [PTR_W-1:0] v_next;
    if (ptr == PTR_W'(DEPTH - 1)) begin
      v_next = {PTR_W{1'b0}};
    end else begin
      v_next = ptr + PTR_W'(1);
    end
    return v_next;
  endfunction

  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == {CNT_W{1'b0}});
  assign o_head  = r_mem[r_rptr];
  assign o_count = r_count;

  // Qualify requests: popping frees the slot a full-FIFO push needs.
  always_comb begin
    w_do_push = 1'b0;
    w_do_pop  = 1'b0;
    if (i_flush) begin
      w_do_push = 1'b0;
      w_do_pop  = 1'b0;
    end else begin
      w_do_pop  = i_pop & ~o_empty;
      w_do_push = i_push & (~o_full | w_do_pop);
    end
  end

  // Storage write; contents need no reset because count gates visibility.
  always_ff @(posedge i_clk) begin
    if (w_do_push && !i_rst) begin
      r_mem[r_wptr] <= i_push_data;
    end
  end

  // Pointers and occupancy counter.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      r_wptr  <= {PTR_W{1'b0}};
      r_rptr  <= {PTR_W{1'b0}};
      r_count <= {CNT_W{1'b0}};
    end else begin
      if (w_do_push) begin
        r_wptr <= ptr_inc(r_wptr);
      end
      if (w_do_pop) begin
        r_rptr <= ptr_inc(r_rptr);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// ----------------------------------------------------------------------------
// instr_fetch_unit
// Fetch stage: PC register, local synchronous instruction memory, one
// outstanding read, and a small buffer feeding the core through valid/ready.
// Ports:
//   clock_i, reset_i            : clock, synchronous active-high reset
//   imem_we_i/waddr_i/wdata_i   : program-load write port (any state)
//   start_i                     : IDLE -> FETCH
//   redirect_i, redirect_pc_i   : flush and refetch from target (word aligned)
//   instr_ready_i               : core accepts the presented instruction
//   instr_valid_o, instruction_o, pc_o : presented instruction (0 when idle)
//   write_ena_o                 : instr_valid_o & instr_ready_i
// ----------------------------------------------------------------------------
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int          IMEM_DEPTH = 256,
  parameter int          FIFO_DEPTH = 2,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  localparam int         ADDR_W     = $clog2(IMEM_DEPTH)
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              imem_we_i,
  input  logic [ADDR_W-1:0] imem_waddr_i,
  input  logic [31:0]       imem_wdata_i,
  input  logic              start_i,
  input  logic              redirect_i,
  input  logic [31:0]       redirect_pc_i,
  input  logic              instr_ready_i,
  output logic              instr_valid_o,
  output logic [31:0]       instruction_o,
  output logic [31:0]       pc_o,
  output logic              write_ena_o
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  fetch_state_e      r_state;
  fetch_state_e      w_state_next;
  logic [31:0]       r_pc;
  logic              r_inflight;
  logic [31:0]       r_issued_pc;
  logic [31:0]       r_rdata;
  logic [31:0]       r_imem [IMEM_DEPTH];

  fetch_entry_t      w_head;
  fetch_entry_t      w_push_data;
  logic [CNT_W-1:0]  w_count;
  logic              w_full;
  logic              w_empty;
  logic              w_pop;
  logic              w_push;
  logic [CNT_W:0]    w_occupancy;
  logic              w_room;
  logic              w_ebreak_inflight;
  logic              w_issue;
  logic [ADDR_W-1:0] w_rd_addr;

  assign w_rd_addr = r_pc[ADDR_W+1:2];

  // Handshake, buffer occupancy and issue decision.
  always_comb begin
    w_pop             = ~w_empty & instr_ready_i;
    w_push            = r_inflight & ~redirect_i;
    w_push_data.instr = r_rdata;
    w_push_data.pc    = r_issued_pc;
    // The in-flight read already owns a slot, so count it as occupied.
    w_occupancy       = {1'b0, w_count} + {{CNT_W{1'b0}}, r_inflight}
                        - {{CNT_W{1'b0}}, w_pop};
    w_room            = (w_occupancy < (CNT_W+1)'(FIFO_DEPTH)) & (~w_full | w_pop);
    // Stop issuing as soon as EBREAK is in flight so nothing follows it.
    w_ebreak_inflight = r_inflight & (r_rdata == EBREAK_INSTR);
    if ((r_state == FETCH) && !redirect_i) begin
      w_issue = w_room & ~w_ebreak_inflight;
    end else begin
      w_issue = 1'b0;
    end
  end

  // Next-state logic for the fetch controller.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (start_i) begin
          w_state_next = FETCH;
        end else begin
          w_state_next = IDLE;
        end
      end
      FETCH: begin
        if (redirect_i) begin
          w_state_next = FETCH;
        end else if (w_ebreak_inflight) begin
          w_state_next = HALT;
        end else begin
          w_state_next = FETCH;
        end
      end
      HALT: begin
        if (redirect_i) begin
          w_state_next = FETCH;
        end else begin
          w_state_next = HALT;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // PC register: redirect overrides sequential advance.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      r_pc <= RESET_PC;
    end else if (redirect_i) begin
      r_pc <= align_pc(redirect_pc_i);
    end else if (w_issue) begin
      r_pc <= r_pc + 32'd4;
    end else begin
      r_pc <= r_pc;
    end
  end

  // In-flight tracking; a redirect suppresses issue, which drops the flag.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      r_inflight  <= 1'b0;
      r_issued_pc <= 32'h0000_0000;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_issued_pc <= r_pc;
      end else begin
        r_issued_pc <= r_issued_pc;
      end
    end
  end

  // Instruction memory: not reset; a same-address read sees the old word.
  always_ff @(posedge clock_i) begin
    if (imem_we_i) begin
      r_imem[imem_waddr_i] <= imem_wdata_i;
    end
    if (w_issue) begin
      r_rdata <= r_imem[w_rd_addr];
    end
  end

  fetch_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .i_clk      (clock_i),
    .i_rst      (reset_i),
    .i_flush    (redirect_i),
    .i_push     (w_push),
    .i_push_data(w_push_data),
    .i_pop      (w_pop),
    .o_head     (w_head),
    .o_count    (w_count),
    .o_full     (w_full),
    .o_empty    (w_empty)
  );

  assign instr_valid_o = ~w_empty;
  assign instruction_o = w_empty ? 32'h0000_0000 : w_head.instr;
  assign pc_o          = w_empty ? 32'h0000_0000 : w_head.pc;
  assign write_ena_o   = ~w_empty & instr_ready_i;

endmodule

// File: tb/tb_instr_fetch_unit.sv
`timescale 1ns/1ps
module tb_instr_fetch_unit;

  localparam int          DEPTH  = 2;
  localparam int          MEMW   = 256;
  localparam logic [31:0] EBREAK = 32'h0010_0073;

  logic        clk = 1'b0;
  logic        reset_i, imem_we_i, start_i, redirect_i, instr_ready_i;
  logic [7:0]  imem_waddr_i;
  logic [31:0] imem_wdata_i, redirect_pc_i;
  logic        instr_valid_o, write_ena_o;
  logic [31:0] instruction_o, pc_o;

  always #5 clk = ~clk;

  instr_fetch_unit dut (
    .clock_i      (clk),
    .reset_i      (reset_i),
    .imem_we_i    (imem_we_i),
    .imem_waddr_i (imem_waddr_i),
    .imem_wdata_i (imem_wdata_i),
    .start_i      (start_i),
    .redirect_i   (redirect_i),
    .redirect_pc_i(redirect_pc_i),
    .instr_ready_i(instr_ready_i),
    .instr_valid_o(instr_valid_o),
    .instruction_o(instruction_o),
    .pc_o         (pc_o),
    .write_ena_o  (write_ena_o)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  // Every read issued but not yet delivered sits in mq with the cycle at
  // which it becomes visible; its length is buffered + in-flight words.
  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    int          avail;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_mem [MEMW];
  logic [31:0] prog  [MEMW];
  int          m_state;        // 0 idle, 1 fetching, 2 halted
  logic [31:0] m_pc;
  bit          m_init = 1'b0;

  always @(negedge clk) begin
    bit          ev;
    logic [31:0] ei, ep;
    ent_t        e;
    ev = (mq.size() > 0) && (mq[0].avail <= cyc);
    ei = ev ? mq[0].instr : 32'h0;
    ep = ev ? mq[0].pc    : 32'h0;
    if (m_init) begin
      chk("model_valid", instr_valid_o, ev);
      chk("model_instr", instruction_o, ei);
      chk("model_pc", pc_o, ep);
      chk("model_write_ena", write_ena_o, ev & instr_ready_i);
    end
    if (reset_i) begin
      mq.delete();
      m_state = 0;
      m_pc    = 32'h0;
      m_init  = 1'b1;
    end else if (redirect_i) begin
      mq.delete();
      m_pc = redirect_pc_i & 32'hFFFF_FFFC;
      if (m_state != 0 || start_i) m_state = 1;
    end else begin
      if (ev && instr_ready_i) void'(mq.pop_front());
      if (m_state == 1 && mq.size() < DEPTH) begin
        e.instr = m_mem[m_pc[9:2]];
        e.pc    = m_pc;
        e.avail = cyc + 2;
        mq.push_back(e);
        m_pc = m_pc + 32'd4;
        if (e.instr == EBREAK) m_state = 2;
      end
      if (m_state == 0 && start_i) m_state = 1;
    end
    if (imem_we_i) m_mem[imem_waddr_i] = imem_wdata_i;
    cyc++;
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
  endtask

  // Start in this cycle, then advance to cycle 3 (first valid).
  task automatic start_to_first();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    ticks(2);
  endtask

  task automatic redirect_to(input logic [31:0] tgt);
    redirect_i    = 1'b1;
    redirect_pc_i = tgt;
    tick();
    redirect_i = 1'b0;
  endtask

  initial begin
    reset_i = 1'b1; imem_we_i = 1'b0; imem_waddr_i = 8'h0; imem_wdata_i = 32'h0;
    start_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'h0; instr_ready_i = 1'b0;
    ticks(2);
    reset_i = 1'b0;
    @(negedge clk);
    chk("reset_valid", instr_valid_o, 32'h0);
    chk("reset_instr", instruction_o, 32'h0);
    chk("reset_pc", pc_o, 32'h0);
    chk("reset_we", write_ena_o, 32'h0);

    // Program load while idle.
    for (int i = 0; i < MEMW; i++) begin
      case (i)
        0:       prog[i] = 32'h0010_8093;
        1:       prog[i] = 32'h0010_8133;
        2:       prog[i] = 32'h0011_01b3;
        3:       prog[i] = EBREAK;
        default: prog[i] = $urandom() & 32'hFFEF_FFFF;  // never EBREAK
      endcase
    end
    for (int i = 0; i < MEMW; i++) begin
      imem_we_i = 1'b1; imem_waddr_i = 8'(i); imem_wdata_i = prog[i];
      tick();
    end
    imem_we_i = 1'b0;

    // 1 + 4: straight-line fetch up to EBREAK, then halt.
    instr_ready_i = 1'b1;
    start_to_first();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t1_valid", instr_valid_o, 32'h1);
      chk("t1_pc", pc_o, 32'(i * 4));
      chk("t1_instr", instruction_o, prog[i]);
      chk("t1_we", write_ena_o, 32'h1);
      tick();
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t4_halted_valid", instr_valid_o, 32'h0);
      tick();
    end
    redirect_to(32'h0);
    ticks(2);
    @(negedge clk);
    chk("t4_resume_pc", pc_o, 32'h0);
    chk("t4_resume_instr", instruction_o, 32'h0010_8093);
    ticks(8);

    // 2: back-pressure from cycle 3 through 8.
    do_reset();
    instr_ready_i = 1'b0;
    start_to_first();
    ticks(5);
    @(negedge clk);
    chk("t2_hold_valid", instr_valid_o, 32'h1);
    chk("t2_hold_pc", pc_o, 32'h0);
    chk("t2_hold_instr", instruction_o, 32'h0010_8093);
    chk("t2_hold_we", write_ena_o, 32'h0);
    tick();
    instr_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t2_release_pc", pc_o, 32'(i * 4));
      tick();
    end
    ticks(6);

    // 3: redirect with a full buffer; stale words must vanish.
    do_reset();
    instr_ready_i = 1'b0;
    start_to_first();
    ticks(3);
    redirect_to(32'h0000_0012);
    @(negedge clk);
    chk("t3_drop_valid", instr_valid_o, 32'h0);
    tick();
    @(negedge clk);
    chk("t3_gap_valid", instr_valid_o, 32'h0);
    tick();
    @(negedge clk);
    chk("t3_new_valid", instr_valid_o, 32'h1);
    chk("t3_new_pc", pc_o, 32'h0000_0010);
    chk("t3_new_instr", instruction_o, prog[4]);
    instr_ready_i = 1'b1;
    ticks(4);

    // 5: address wrap past the last memory word.
    redirect_to(32'h0000_03F8);
    ticks(2);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t5_wrap_pc", pc_o, 32'h0000_03F8 + 32'(i * 4));
      chk("t5_wrap_instr", instruction_o, (i == 2) ? prog[0] : prog[254 + i]);
      tick();
    end

    // 6: reset during steady fetch, then restart.
    redirect_to(32'h0000_0100);
    ticks(5);
    do_reset();
    @(negedge clk);
    chk("t6_rst_valid", instr_valid_o, 32'h0);
    chk("t6_rst_instr", instruction_o, 32'h0);
    chk("t6_rst_pc", pc_o, 32'h0);
    chk("t6_rst_we", write_ena_o, 32'h0);
    tick();
    start_to_first();
    @(negedge clk);
    chk("t6_restart_pc", pc_o, 32'h0);
    chk("t6_restart_instr", instruction_o, 32'h0010_8093);
    tick();

    // Randomized traffic checked by the model every cycle.
    for (int i = 0; i < 4000; i++) begin
      instr_ready_i = ($urandom_range(99) < 70);
      redirect_i    = ($urandom_range(99) < 3);
      redirect_pc_i = ($urandom_range(1) == 0) ? ($urandom() & 32'h0000_03FF) : $urandom();
      start_i       = ($urandom_range(99) < 20);
      reset_i       = ($urandom_range(999) < 4);
      imem_we_i     = ($urandom_range(99) < 5);
      imem_waddr_i  = 8'($urandom());
      imem_wdata_i  = ($urandom_range(7) == 0) ? EBREAK : $urandom();
      tick();
    end
    reset_i = 1'b0; redirect_i = 1'b0; start_i = 1'b0; imem_we_i = 1'b0;
    ticks(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
